// File: rtl/glb_stream_pkg.sv
// Shared definitions for the block-stream arbiter: end-of-streams token,
// header length field position and the arbiter FSM state encoding.
package glb_stream_pkg;

   localparam logic [16:0] DONE_TOKEN = 17'h10100;
   localparam int          LEN_LSB    = 0;
   localparam int          LEN_W      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PAY  = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin channel picker: searches the masked requests starting just after
// the last accepted channel; the pointer only moves when a grant is taken.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              flush,
   input  logic [NUM_CH-1:0] req,
   input  logic              accept,
   output logic              grant_valid,
   output logic [CH_W-1:0]   grant_ch
);

   logic [CH_W-1:0] last_ch;
   logic [CH_W-1:0] idx;

   // Pointer holds the last granted channel; NUM_CH-1 puts channel 0 first.
   always_ff @(posedge clk) begin
      if (flush) begin
         last_ch <= CH_W'(NUM_CH - 1);
      end else if (accept && grant_valid) begin
         last_ch <= grant_ch;
      end
   end

   // Walk from the farthest candidate to the nearest so the nearest wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      idx         = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = CH_W'((int'(last_ch) + k) % NUM_CH);
         if (req[idx]) begin
            grant_valid = 1'b1;
            grant_ch    = idx;
         end
      end
   end

endmodule

// File: rtl/glb_block_arbiter.sv
// Merges NUM_CH block streams (header + L payload words) into one output
// stream, never interleaving blocks, and reports when every channel has ended.
//
//   state | meaning
//   IDLE  | no grant held; pick the next requesting channel round-robin
//   HDR   | forward the granted channel's header, load the payload count
//   PAY   | forward payload words until the count reaches zero
module glb_block_arbiter #(
   parameter  int                NUM_CH     = 4,
   parameter  int                DATA_W     = 17,
   parameter  logic [DATA_W-1:0] DONE_TOKEN = DATA_W'(glb_stream_pkg::DONE_TOKEN),
   localparam int                CH_W       = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     flush,
   input  logic                     clk_en,
   input  logic                     seg_mode,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_ch,
   output logic                     done
);

   import glb_stream_pkg::*;

   state_t             state, state_nxt;
   logic [CH_W-1:0]    gnt_ch, gnt_ch_nxt;
   logic [LEN_W-1:0]   cnt, cnt_nxt;
   logic               first_blk, first_blk_nxt;
   logic               blk_end;
   logic [NUM_CH-1:0]  eos_seen, eos_set;
   logic [NUM_CH-1:0]  done_bits;
   logic               out_is_done;
   logic               out_accept;
   logic               hs;
   logic [DATA_W-1:0]  word;
   logic [LEN_W-1:0]   len;
   logic [NUM_CH-1:0]  arb_req;
   logic               arb_valid;
   logic               arb_accept;
   logic [CH_W-1:0]    arb_ch;

   assign word       = in_data[int'(gnt_ch)*DATA_W +: DATA_W];
   assign len        = word[LEN_LSB +: LEN_W];
   assign out_accept = out_ready | ~out_valid;
   assign hs         = clk_en & in_valid[gnt_ch] & in_ready[gnt_ch];

   // A channel that has sent its end token is excluded until the next flush.
   assign arb_req    = in_valid & ch_en & ~eos_seen;
   assign arb_accept = (state == IDLE) & clk_en;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr (
      .clk         (clk),
      .flush       (flush),
      .req         (arb_req),
      .accept      (arb_accept),
      .grant_valid (arb_valid),
      .grant_ch    (arb_ch)
   );

   always_comb begin
      in_ready = '0;
      if ((state == HDR || state == PAY) && out_accept) begin
         in_ready[gnt_ch] = ch_en[gnt_ch];
      end
   end

   always_comb begin
      state_nxt     = state;
      gnt_ch_nxt    = gnt_ch;
      cnt_nxt       = cnt;
      first_blk_nxt = first_blk;
      blk_end       = 1'b0;
      eos_set       = '0;
      case (state)
         IDLE: begin
            if (clk_en && arb_valid) begin
               state_nxt     = HDR;
               gnt_ch_nxt    = arb_ch;
               first_blk_nxt = 1'b1;
            end
         end
         HDR: begin
            if (hs) begin
               if (word == DONE_TOKEN) begin
                  eos_set[gnt_ch] = 1'b1;
                  state_nxt       = IDLE;
               end else begin
                  cnt_nxt = len;
                  if (len != '0) begin
                     state_nxt = PAY;
                  end else begin
                     blk_end = 1'b1;
                  end
               end
            end
         end
         PAY: begin
            if (hs) begin
               cnt_nxt = cnt - LEN_W'(1);
               if (cnt == LEN_W'(1)) begin
                  blk_end = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Segmented transfers keep the grant for the second (crd) block.
      if (blk_end) begin
         if (seg_mode && first_blk) begin
            state_nxt     = HDR;
            first_blk_nxt = 1'b0;
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         state       <= IDLE;
         gnt_ch      <= '0;
         cnt         <= '0;
         first_blk   <= 1'b0;
         eos_seen    <= '0;
         done_bits   <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_ch      <= '0;
         out_is_done <= 1'b0;
      end else if (clk_en) begin
         state     <= state_nxt;
         gnt_ch    <= gnt_ch_nxt;
         cnt       <= cnt_nxt;
         first_blk <= first_blk_nxt;
         eos_seen  <= eos_seen | eos_set;
         if (hs) begin
            out_data    <= word;
            out_ch      <= gnt_ch;
            out_valid   <= 1'b1;
            out_is_done <= (state == HDR) && (word == DONE_TOKEN);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // Done is credited only once the end token has left the output stage.
         if (out_valid && out_ready && out_is_done) begin
            done_bits[out_ch] <= 1'b1;
         end
      end
   end

   assign done = &(done_bits | ~ch_en);

endmodule
